// File: rtl/pipe_pkg.sv
// Shared defaults for the decode/execute pipeline stage register: payload and
// control widths, the bubble control word and the control-field layout.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 128;
  localparam int unsigned CTRL_W_DEF = 16;
  localparam logic [CTRL_W_DEF-1:0] BUBBLE_CTRL_DEF = '0;

  // Decode/execute control-field offsets (LSB position and width).
  localparam int unsigned CTRL_ALU_OP_LSB     = 0;
  localparam int unsigned CTRL_ALU_OP_W       = 2;
  localparam int unsigned CTRL_ALUSRC_BIT     = 2;
  localparam int unsigned CTRL_MEM_READ_BIT   = 3;
  localparam int unsigned CTRL_MEM_WRITE_BIT  = 4;
  localparam int unsigned CTRL_REG_WRITE_BIT  = 5;
  localparam int unsigned CTRL_MEM_TO_REG_BIT = 6;
  localparam int unsigned CTRL_BRANCH_BIT     = 7;
  localparam int unsigned CTRL_JUMP_BIT       = 8;
  localparam int unsigned CTRL_FUNCT3_LSB     = 9;
  localparam int unsigned CTRL_FUNCT3_W       = 3;
  localparam int unsigned CTRL_OPCODE_LSB     = 12;
  localparam int unsigned CTRL_OPCODE_W       = 4;

  // Packed view of the control bundle; field order matches the offsets above.
  typedef struct packed {
    logic [CTRL_OPCODE_W-1:0] opcode;
    logic [CTRL_FUNCT3_W-1:0] funct3;
    logic                     jump;
    logic                     branch;
    logic                     mem_to_reg;
    logic                     reg_write;
    logic                     mem_write;
    logic                     mem_read;
    logic                     alusrc;
    logic [CTRL_ALU_OP_W-1:0] alu_op;
  } dx_ctrl_t;

  // Number of held entries from the main and skid valid flags.
  function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Second (skid) entry of the pipeline stage register. Holds one beat that
// arrived while the main entry was occupied and stalled downstream.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned            DATA_W      = DATA_W_DEF,
  parameter int unsigned            CTRL_W      = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0]      BUBBLE_CTRL = BUBBLE_CTRL_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              take_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic              valid_next_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Next-state: clear beats load, load beats take (never both from the top).
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end else if (take_i) begin
      valid_d = 1'b0;
    end
  end

  // Entry register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      ctrl_q  <= BUBBLE_CTRL;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o      = valid_q;
  assign valid_next_o = valid_d;
  assign ctrl_o       = ctrl_q;
  assign data_o       = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Decode/execute pipeline stage register with valid/ready handshakes,
// hazard stall and flush. Define PIPE_STAGE_SKID_EN to build the two-entry
// skid version with a registered in_ready_o; otherwise a single entry.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned            DATA_W      = DATA_W_DEF,
  parameter int unsigned            CTRL_W      = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0]      BUBBLE_CTRL = BUBBLE_CTRL_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occ_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              accept;
  logic              drain;

  assign accept = in_valid_i && in_ready_o;
  assign drain  = valid_q && out_ready_i;

`ifdef PIPE_STAGE_SKID_EN

  logic              skid_valid;
  logic              skid_valid_d;
  logic              skid_load;
  logic              skid_take;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              ready_q, ready_d;

  pipe_skid_buf #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .BUBBLE_CTRL (BUBBLE_CTRL)
  ) u_skid (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (flush_i),
    .load_i       (skid_load),
    .take_i       (skid_take),
    .ctrl_i       (in_ctrl_i),
    .data_i       (in_data_i),
    .valid_o      (skid_valid),
    .valid_next_o (skid_valid_d),
    .ctrl_o       (skid_ctrl),
    .data_o       (skid_data)
  );

  // Ready comes from a register; stall and flush only gate it, so there is
  // no path from out_ready_i.
  assign in_ready_o = rst_ni && (flush_i || (!stall_i && ready_q));

  // Main-entry next state and skid load/take; main entry always drains first.
  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    data_d    = data_q;
    skid_load = 1'b0;
    skid_take = 1'b0;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (!stall_i) begin
      if (skid_valid) begin
        // Both entries full: ready is low, so only a drain can occur.
        if (drain) begin
          valid_d   = 1'b1;
          ctrl_d    = skid_ctrl;
          data_d    = skid_data;
          skid_take = 1'b1;
        end
      end else if (accept && (!valid_q || drain)) begin
        valid_d = 1'b1;
        ctrl_d  = in_ctrl_i;
        data_d  = in_data_i;
      end else if (accept) begin
        skid_load = 1'b1;
      end else if (drain) begin
        valid_d = 1'b0;
      end
    end
    ready_d = (occ_count(valid_d, skid_valid_d) != 2'd2);
  end

  // Main entry and registered ready; ready is high out of reset (stage empty).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      ctrl_q  <= BUBBLE_CTRL;
      data_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  assign occ_o = occ_count(valid_q, skid_valid);

`else

  // Single entry: accept when empty or draining this cycle.
  assign in_ready_o = rst_ni && (flush_i || (!stall_i && (!valid_q || out_ready_i)));

  // Main-entry next state: flush, then stall hold, then load or drain.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (!stall_i) begin
      if (accept) begin
        valid_d = 1'b1;
        ctrl_d  = in_ctrl_i;
        data_d  = in_data_i;
      end else if (drain) begin
        valid_d = 1'b0;
      end
    end
  end

  // Main entry register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      ctrl_q  <= BUBBLE_CTRL;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign occ_o = occ_count(valid_q, 1'b0);

`endif

  // Empty stage presents the bubble control word; payload keeps its last value.
  assign out_valid_o = valid_q;
  assign out_ctrl_o  = valid_q ? ctrl_q : BUBBLE_CTRL;
  assign out_data_o  = data_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; skid expectations follow
// PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 128;
  localparam int CW = 16;
  localparam logic [CW-1:0] BUB = 16'h0000;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  logic          stall_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [CW-1:0] in_ctrl_i;
  logic [DW-1:0] in_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [CW-1:0] out_ctrl_o;
  logic [DW-1:0] out_data_o;
  logic [1:0]    occ_o;

  int checks = 0;
  int passes = 0;

  always #5 clk_i = ~clk_i;

  pipe_stage_reg dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .stall_i     (stall_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_ctrl_i   (in_ctrl_i),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_ctrl_o  (out_ctrl_o),
    .out_data_o  (out_data_o),
    .occ_o       (occ_o)
  );

  function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
    return 16'hC000 ^ d[15:0];
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d);
    in_valid_i = v;
    in_data_i  = d;
    in_ctrl_i  = ctrl_of(d);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; flush_i = 1'b0; stall_i = 1'b0; out_ready_i = 1'b1;
    drive(1'b1, 'h55);
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (out_valid_o !== 1'b0) $display("FAIL rst_valid got=%b exp=0", out_valid_o); else passes++;
      checks++; if (out_ctrl_o !== BUB) $display("FAIL rst_ctrl got=%h exp=%h", out_ctrl_o, BUB); else passes++;
      checks++; if (occ_o !== 2'd0) $display("FAIL rst_occ got=%0d exp=0", occ_o); else passes++;
      checks++; if (in_ready_o !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", in_ready_o); else passes++;
    end
    rst_ni = 1'b1;
    drive(1'b0, '0);
    settle();
    checks++; if (in_ready_o !== 1'b1) $display("FAIL rel_in_ready got=%b exp=1", in_ready_o); else passes++;
    $display("test_reset done");
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 'h77);
    step();
    checks++; if (out_data_o !== DW'(32'h77)) $display("FAIL mid_load got=%h exp=77", out_data_o); else passes++;
    rst_ni = 1'b0; flush_i = 1'b1; stall_i = 1'b1;
    drive(1'b1, 'h78);
    settle();
    checks++; if (in_ready_o !== 1'b0) $display("FAIL mid_in_ready got=%b exp=0", in_ready_o); else passes++;
    step();
    checks++; if (out_valid_o !== 1'b0) $display("FAIL mid_valid got=%b exp=0", out_valid_o); else passes++;
    checks++; if (occ_o !== 2'd0) $display("FAIL mid_occ got=%0d exp=0", occ_o); else passes++;
    checks++; if (out_data_o !== '0) $display("FAIL mid_data got=%h exp=0", out_data_o); else passes++;
    rst_ni = 1'b1; flush_i = 1'b0; stall_i = 1'b0;
    drive(1'b0, '0);
    step();
    checks++; if (out_valid_o !== 1'b0) $display("FAIL mid_post_valid got=%b exp=0", out_valid_o); else passes++;
    $display("test_reset_mid done");
  endtask

  task automatic test_stream();
    out_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i));
      settle();
      checks++; if (in_ready_o !== 1'b1) $display("FAIL str_in_ready beat=%0d got=%b exp=1", i, in_ready_o); else passes++;
      step();
      checks++; if (out_valid_o !== 1'b1) $display("FAIL str_valid beat=%0d got=%b exp=1", i, out_valid_o); else passes++;
      checks++; if (out_data_o !== DW'(i)) $display("FAIL str_data beat=%0d got=%h exp=%h", i, out_data_o, i); else passes++;
      checks++; if (out_ctrl_o !== ctrl_of(DW'(i))) $display("FAIL str_ctrl beat=%0d got=%h exp=%h", i, out_ctrl_o, ctrl_of(DW'(i))); else passes++;
      checks++; if (occ_o !== 2'd1) $display("FAIL str_occ beat=%0d got=%0d exp=1", i, occ_o); else passes++;
      $display("stream beat %0d out=%h", i, out_data_o);
    end
    drive(1'b0, '0);
    step();
    checks++; if (out_valid_o !== 1'b0) $display("FAIL str_end_valid got=%b exp=0", out_valid_o); else passes++;
    checks++; if (out_ctrl_o !== BUB) $display("FAIL str_end_ctrl got=%h exp=%h", out_ctrl_o, BUB); else passes++;
    checks++; if (out_data_o !== DW'(8)) $display("FAIL str_end_data got=%h exp=8", out_data_o); else passes++;
  endtask

  task automatic test_stall();
    out_ready_i = 1'b1;
    drive(1'b1, 'hA5);
    step();
    checks++; if (out_data_o !== DW'(32'hA5)) $display("FAIL stl_load got=%h exp=a5", out_data_o); else passes++;
    stall_i = 1'b1;
    drive(1'b1, 'hBB);
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if (in_ready_o !== 1'b0) $display("FAIL stl_in_ready cyc=%0d got=%b exp=0", c, in_ready_o); else passes++;
      step();
      checks++; if (out_valid_o !== 1'b1) $display("FAIL stl_valid cyc=%0d got=%b exp=1", c, out_valid_o); else passes++;
      checks++; if (out_data_o !== DW'(32'hA5)) $display("FAIL stl_data cyc=%0d got=%h exp=a5", c, out_data_o); else passes++;
      checks++; if (out_ctrl_o !== ctrl_of('hA5)) $display("FAIL stl_ctrl cyc=%0d got=%h exp=%h", c, out_ctrl_o, ctrl_of('hA5)); else passes++;
      checks++; if (occ_o !== 2'd1) $display("FAIL stl_occ cyc=%0d got=%0d exp=1", c, occ_o); else passes++;
      $display("stall cycle %0d out=%h", c, out_data_o);
    end
    stall_i = 1'b0;
    drive(1'b0, '0);
    step();
    checks++; if (out_valid_o !== 1'b0) $display("FAIL stl_drain_valid got=%b exp=0", out_valid_o); else passes++;
    checks++; if (out_data_o !== DW'(32'hA5)) $display("FAIL stl_no_new got=%h exp=a5", out_data_o); else passes++;
  endtask

  task automatic test_flush();
    out_ready_i = 1'b1;
    drive(1'b1, 'h33);
    step();
    checks++; if (occ_o !== 2'd1) $display("FAIL fl_occ_pre got=%0d exp=1", occ_o); else passes++;
    stall_i = 1'b1; flush_i = 1'b1;
    drive(1'b1, 'h44);
    settle();
    checks++; if (in_ready_o !== 1'b1) $display("FAIL fl_in_ready got=%b exp=1", in_ready_o); else passes++;
    step();
    checks++; if (out_valid_o !== 1'b0) $display("FAIL fl_valid got=%b exp=0", out_valid_o); else passes++;
    checks++; if (out_ctrl_o !== BUB) $display("FAIL fl_ctrl got=%h exp=%h", out_ctrl_o, BUB); else passes++;
    checks++; if (occ_o !== 2'd0) $display("FAIL fl_occ got=%0d exp=0", occ_o); else passes++;
    stall_i = 1'b0; flush_i = 1'b0;
    drive(1'b0, '0);
    step();
    checks++; if (out_valid_o !== 1'b0) $display("FAIL fl_lost got=%b exp=0", out_valid_o); else passes++;
    $display("test_flush done");
  endtask

  task automatic test_skid();
    logic [DW-1:0] got[$];
    logic [DW-1:0] vals[3];
    int idx;
    int max_occ;
    logic rdy_c1;
    logic rdy_c2;
    vals[0] = DW'(32'h10); vals[1] = DW'(32'h11); vals[2] = DW'(32'h12);
    idx = 0; max_occ = 0; rdy_c1 = 1'bx; rdy_c2 = 1'bx;
    for (int cyc = 0; cyc < 10; cyc++) begin
      out_ready_i = (cyc != 1);
      if (idx < 3) drive(1'b1, vals[idx]); else drive(1'b0, '0);
      settle();
      if (cyc == 1) rdy_c1 = in_ready_o;
      if (cyc == 2) rdy_c2 = in_ready_o;
      if (out_valid_o && out_ready_i) begin
        got.push_back(out_data_o);
        $display("skid drained %h at cycle %0d", out_data_o, cyc);
      end
      if (in_valid_i && in_ready_o) idx++;
      step();
      if (int'(occ_o) > max_occ) max_occ = int'(occ_o);
    end
    checks++; if (got.size() !== 3) $display("FAIL skid_count got=%0d exp=3", got.size()); else passes++;
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) begin
        checks++; if (got[i] !== vals[i]) $display("FAIL skid_order idx=%0d got=%h exp=%h", i, got[i], vals[i]); else passes++;
      end
    end
`ifdef PIPE_STAGE_SKID_EN
    checks++; if (max_occ !== 2) $display("FAIL skid_max_occ got=%0d exp=2", max_occ); else passes++;
    checks++; if (rdy_c1 !== 1'b1) $display("FAIL skid_rdy_c1 got=%b exp=1", rdy_c1); else passes++;
    checks++; if (rdy_c2 !== 1'b0) $display("FAIL skid_rdy_c2 got=%b exp=0", rdy_c2); else passes++;
`else
    checks++; if (max_occ !== 1) $display("FAIL noskid_max_occ got=%0d exp=1", max_occ); else passes++;
    checks++; if (rdy_c1 !== 1'b0) $display("FAIL noskid_rdy_c1 got=%b exp=0", rdy_c1); else passes++;
    checks++; if (rdy_c2 !== 1'b1) $display("FAIL noskid_rdy_c2 got=%b exp=1", rdy_c2); else passes++;
`endif
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; stall_i = 1'b0; out_ready_i = 1'b0;
    in_valid_i = 1'b0; in_ctrl_i = '0; in_data_i = '0;
    test_reset();
    test_reset_mid();
    test_stream();
    test_stall();
    test_flush();
    test_skid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 128, width of the datapath payload (operands, offset, register indices).
REQ-002 SHALL have parameter CTRL_W, default 16, width of the control bundle (opcode, funct3, alusrc, mem/reg/branch/jump flags, alu_op).
REQ-003 SHALL have parameter BUBBLE_CTRL, default all-zero, the control value presented whenever the stage is empty.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1, reset that is synchronous and active-low.
REQ-006 SHALL have port flush_i, input, 1, kill all held entries and the incoming beat.
REQ-007 SHALL have port stall_i, input, 1, freeze the stage (hazard unit).
REQ-008 SHALL have port in_valid_i, input, 1, upstream beat valid.
REQ-009 SHALL have port in_ready_o, output, 1, stage accepts a beat this cycle.
REQ-010 SHALL have port in_ctrl_i, input, CTRL_W, upstream control bundle.
REQ-011 SHALL have port in_data_i, input, DATA_W, upstream payload.
REQ-012 SHALL have port out_valid_o, output, 1, downstream beat valid.
REQ-013 SHALL have port out_ready_i, input, 1, downstream accepts.
REQ-014 SHALL have port out_ctrl_o, output, CTRL_W, registered control bundle.
REQ-015 SHALL have port out_data_o, output, DATA_W, registered payload.
REQ-016 SHALL have port occ_o, output, 2, number of held entries (0..2).

Function
REQ-017 SHALL transfer a beat on in_valid_i && in_ready_o, and on out_valid_o && out_ready_i.
REQ-018 SHALL present an accepted beat on the outputs exactly 1 cycle after acceptance when the stage was empty.
REQ-019 SHALL drive out_ctrl_o = BUBBLE_CTRL whenever out_valid_o = 0; out_data_o holds its last value.
REQ-020 SHALL, with stall_i = 1 and flush_i = 0: drive in_ready_o = 0 and hold out_valid_o, out_ctrl_o, out_data_o and occ_o unchanged; out_ready_i is ignored.
REQ-021 SHALL, with flush_i = 1, drive in_ready_o = 1, discard the incoming beat and, next cycle, show out_valid_o = 0, out_ctrl_o = BUBBLE_CTRL and occ_o = 0; flush overrides stall and all handshakes.
REQ-022 SHALL preserve beat order; no beat is duplicated or dropped except by flush.
REQ-023 SHALL, with occ_o = 1 and simultaneous accept plus drain, replace the held entry with the new beat and keep occ_o = 1.
REQ-024 SHALL, without skid, drive in_ready_o = !stall_i && (!out_valid_o || out_ready_i), combinationally.

Reset
REQ-025 SHALL, while rst_ni = 0 at a clock edge, clear out_valid_o to 0, out_ctrl_o to BUBBLE_CTRL, out_data_o to 0 and occ_o to 0, and empty the skid entry.
REQ-026 SHALL drive in_ready_o = 0 while rst_ni = 0, and follow REQ-024 or REQ-029 from the first cycle after release.
REQ-027 SHALL, when reset is asserted mid-transfer, discard all beats; reset outranks flush and stall.

Configuration
REQ-028 SHALL use macro PIPE_STAGE_SKID_EN to select the skid-buffer build.
REQ-029 SHALL, with PIPE_STAGE_SKID_EN defined, add a second entry and make in_ready_o a register equal to !stall && (occ < 2 after this cycle's update), with no combinational path from out_ready_i to in_ready_o.
REQ-030 SHALL, with PIPE_STAGE_SKID_EN defined, fill the skid entry when a beat is accepted while the main entry is held and not drained, and give the main entry priority to drain.
REQ-031 SHALL, with PIPE_STAGE_SKID_EN defined, sustain 1 beat/cycle.
REQ-032 SHALL, without PIPE_STAGE_SKID_EN, be a single entry, with occ_o limited to 0 or 1.

Structure
REQ-033 SHALL take default DATA_W, CTRL_W and BUBBLE_CTRL from package pipe_pkg, along with the decode/execute control-field offsets.
REQ-034 SHALL implement the skid entry as sub-module pipe_skid_buf, instantiated only under PIPE_STAGE_SKID_EN.

Verification
REQ-035 SHALL cover reset: hold rst_ni = 0 for 2 cycles with in_valid_i = 1 -> out_valid_o = 0, out_ctrl_o = BUBBLE_CTRL, occ_o = 0, in_ready_o = 0.
REQ-036 SHALL cover streaming: 8 beats, data 0x1..0x8, out_ready_i = 1 -> outputs 0x1..0x8 on consecutive cycles, 1-cycle latency.
REQ-037 SHALL cover stall: stall_i = 1 for 3 cycles while holding data 0xA5 -> out stays 0xA5/valid, in_ready_o = 0, no new beat accepted.
REQ-038 SHALL cover flush: flush_i with stall_i = 1 and occ_o = 1 -> next cycle out_valid_o = 0, out_ctrl_o = BUBBLE_CTRL, incoming beat lost.
REQ-039 SHALL cover skid (macro on): out_ready_i = 0 for 1 cycle during a stream of 0x10, 0x11, 0x12 -> occ_o reaches 2, in_ready_o = 0 next cycle, output order 0x10, 0x11, 0x12 with no loss.
REQ-040 SHALL cover the no-skid build (macro off): the same stimulus as REQ-039 -> in_ready_o tracks out_ready_i in the same cycle and occ_o never exceeds 1.
